// File: rtl/mdu_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: operation codes
// decoded by core control and the two-state sequencing FSM.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic int unsigned mdu_max(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the E stage and the multiply/divide unit.
// The pipeline side is the master, the unit itself is the slave.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall_req;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, wdata,
        input  hi, lo, busy, stall_req
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, wdata,
        output hi, lo, busy, stall_req
    );
endinterface

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned divider producing MIPS quotient/remainder,
// including the divide-by-zero and most-negative / -1 corner cases.
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_signed,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_b_safe;
    logic [WIDTH-1:0] w_uquot;
    logic [WIDTH-1:0] w_urem;

    // Sign/magnitude decomposition; the most-negative magnitude fits as unsigned.
    always_comb begin
        w_a_neg  = i_signed & i_dividend[WIDTH-1];
        w_b_neg  = i_signed & i_divisor[WIDTH-1];
        w_a_mag  = w_a_neg ? (ZERO - i_dividend) : i_dividend;
        w_b_mag  = w_b_neg ? (ZERO - i_divisor) : i_divisor;
        w_b_safe = (w_b_mag == ZERO) ? ONE : w_b_mag;
        w_uquot  = w_a_mag / w_b_safe;
        w_urem   = w_a_mag % w_b_safe;
    end

    // Result selection: truncation toward zero, remainder follows the dividend.
    always_comb begin
        o_quot = ZERO;
        o_rem  = ZERO;
        if (i_divisor == ZERO) begin
            o_quot = ALL_ONES;
            o_rem  = i_dividend;
        end else if (i_signed && (i_dividend == MOST_NEG) && (i_divisor == ALL_ONES)) begin
            o_quot = MOST_NEG;
            o_rem  = ZERO;
        end else begin
            o_quot = (w_a_neg ^ w_b_neg) ? (ZERO - w_uquot) : w_uquot;
            o_rem  = w_a_neg ? (ZERO - w_urem) : w_urem;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the MIPS E stage.
// Results are computed at launch, held in shadows, and committed after the latency.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input logic             clk,
    input logic             reset,
    mult_div_unit_if.slave  bus
);

    localparam int unsigned MAX_LAT = mdu_max(MUL_LAT, DIV_LAT);
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_LAT_C = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_LAT_C = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    mdu_state_e       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_shadow_hi;
    logic [WIDTH-1:0] r_shadow_lo;
    logic             r_busy;

    mdu_op_e          w_op;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic [CW-1:0]    w_lat;

    assign w_op = mdu_op_e'(bus.op);

    // Operands are widened explicitly so both products are exact 2*WIDTH results.
    assign w_prod_s = {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a}
                    * {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b};
    assign w_prod_u = {ZERO_W, bus.src_a} * {ZERO_W, bus.src_b};

    mdu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .i_dividend (bus.src_a),
        .i_divisor  (bus.src_b),
        .i_signed   (w_op == MDU_DIV),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // Result and latency selection for the operation being launched.
    always_comb begin
        w_res_hi = ZERO_W;
        w_res_lo = ZERO_W;
        w_lat    = MUL_LAT_C;
        case (w_op)
            MDU_MULT: begin
                w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_s[WIDTH-1:0];
                w_lat    = MUL_LAT_C;
            end
            MDU_MULTU: begin
                w_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_u[WIDTH-1:0];
                w_lat    = MUL_LAT_C;
            end
            MDU_DIV, MDU_DIVU: begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
                w_lat    = DIV_LAT_C;
            end
            default: begin
                w_res_hi = ZERO_W;
                w_res_lo = ZERO_W;
                w_lat    = MUL_LAT_C;
            end
        endcase
    end

    // Sequencing FSM; start beats mthi/mtlo, and nothing but commit touches HI/LO while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count     <= CNT_ZERO;
            r_hi        <= ZERO_W;
            r_lo        <= ZERO_W;
            r_shadow_hi <= ZERO_W;
            r_shadow_lo <= ZERO_W;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_shadow_hi <= w_res_hi;
                        r_shadow_lo <= w_res_lo;
                        r_count     <= w_lat;
                        r_state     <= ST_BUSY;
                        r_busy      <= 1'b1;
                    end else begin
                        if (bus.mthi) begin
                            r_hi <= bus.wdata;
                        end
                        if (bus.mtlo) begin
                            r_lo <= bus.wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_count == CNT_ONE) begin
                        r_hi    <= r_shadow_hi;
                        r_lo    <= r_shadow_lo;
                        r_count <= CNT_ZERO;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= CNT_ZERO;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.busy      = r_busy;
    assign bus.stall_req = bus.start | r_busy;

endmodule
